fht_coef_addr_gen: RTL and testbench
====================================

# fht_coef_addr_gen

Twiddle-coefficient address sequencer for the FHT core; the read-side driver of the sin/cos coefficient ROM block. On a start pulse it walks every stage and butterfly of one transform pass. For each butterfly it presents a ROM address, the stage-zero flag and the stage index, under a valid/ready handshake. It emits a coefficient-valid strobe aligned with the ROM's one-cycle read latency.

## Interface
- A_BIT, 6, ROM address width; butterflies per stage = 2^A_BIT
- N_STAGE, 8, number of stages per pass (≥2)
- S_BIT, 3, stage index width, ≥ clog2(N_STAGE)
- iCLK  in  1  clock; all state updates on rising edge
- iRESET  in  1  reset, asynchronous, active-high
- iSTART  in  1  start one pass; honoured only in IDLE
- iREADY  in  1  consumer accepts current address this cycle
- oADDR  out  A_BIT  ROM address (drives ROM iADDR)
- oST_ZERO  out  1  high while stage index = 0 (drives ROM iST_ZERO)
- oSTAGE  out  S_BIT  current stage index
- oADDR_VALID  out  1  oADDR/oST_ZERO/oSTAGE valid
- oCOEF_VALID  out  1  ROM q outputs this cycle belong to the address accepted last cycle
- oBUSY  out  1  high in RUN and DONE
- oDONE  out  1  one-cycle pulse at end of pass

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when iSTART = 1; stage counter s = 0, butterfly counter b = 0.
- Accept = oADDR_VALID & iREADY. On accept, b increments. On b = 2^A_BIT−1, b wraps to 0 and s increments.
- RUN → DONE on accept with s = N_STAGE−1 and b = 2^A_BIT−1. DONE → IDLE unconditionally next cycle.
- Address rule: m = min(s, A_BIT), oADDR = (b mod 2^m) << (A_BIT − m). Stage 0 therefore always emits address 0.
- oST_ZERO = (s == 0) & oADDR_VALID. oSTAGE = s.
- iREADY low: counters and outputs hold; oADDR stays stable, so the ROM re-reads the same entry.
- iSTART in RUN or DONE is ignored; no queueing.
- Counter arithmetic is unsigned with a fixed width. No address exceeds 2^A_BIT−1.

## Timing
- Reset values of all outputs: oADDR = 0, oST_ZERO = 0, oSTAGE = 0, oADDR_VALID = 0, oCOEF_VALID = 0, oBUSY = 0, oDONE = 0; FSM = IDLE.
- iSTART sampled at edge k: oADDR_VALID = 1 from cycle k+1, carrying s = 0, b = 0.
- oADDR_VALID = 1 exactly while in RUN.
- oCOEF_VALID(n+1) = accept(n), registered.
- Pass length with iREADY held high: N_STAGE·2^A_BIT cycles of oADDR_VALID.
- oDONE is high in DONE, the cycle after the last accept. It coincides with the final oCOEF_VALID.
- oBUSY rises with oADDR_VALID and falls one cycle after oDONE.
- iRESET asserted mid-pass clears everything immediately, without waiting for a clock edge. No oDONE is produced for the aborted pass.
- iSTART and iRESET together: reset wins.
- A new pass may start at the earliest on the iSTART sampled in the first IDLE cycle after DONE.

## Configuration
- FHT_COEF_ERR_EN defined: adds output oERR (1 bit, reset 0).
  - oERR is sticky: it sets the cycle after iSTART = 1 is sampled while oBUSY = 1.
  - It clears only on iRESET.
- Not defined: the port and its logic are absent; iSTART while busy is silently ignored.

## Test plan
- Reset, then idle 5 cycles, iSTART low -> every output stays 0 and FSM stays IDLE.
- A_BIT=2, N_STAGE=3, iSTART pulse, iREADY=1 -> oADDR sequence 0,0,0,0 | 0,2,0,2 | 0,1,2,3.
  - oST_ZERO high for the first 4 cycles.
  - oSTAGE reads 0,1,2 per group.
  - 12 oCOEF_VALID pulses; oDONE on cycle 13 after start.
- Same configuration, iREADY low for 3 cycles at b=1 of stage 1 -> oADDR held at 2 for 4 cycles.
  - oCOEF_VALID low during the stall.
  - Total pass 15 cycles; sequence otherwise unchanged.
- iRESET asserted at stage 1, b=2 -> all outputs 0 immediately; no oDONE.
  - A following iSTART restarts from s=0, b=0.
- iSTART pulsed at stage 2 -> pass unaffected; still 12 accepts.
  - With FHT_COEF_ERR_EN: oERR=1 from the next cycle until reset.
- Default parameters (6/8), iREADY=1 -> 512 accepts.
  - Stage 7 addresses 0..63 in order; stage 3 pattern 0,8,...,56 repeating.
  - oDONE exactly once.

Source files
------------

// File: rtl/fht_coef_addr_gen.sv
// Twiddle-coefficient address sequencer for the FHT core.
// Walks every stage and butterfly of one transform pass on a start pulse.
// For each butterfly it presents a coefficient ROM address under a
// valid/ready handshake. oCOEF_VALID marks the ROM data that belongs to the
// address accepted in the previous cycle.
// Optional build macro: FHT_COEF_ERR_EN adds the sticky oERR output.
module fht_coef_addr_gen #(
    parameter int unsigned A_BIT   = 6,
    parameter int unsigned N_STAGE = 8,
    parameter int unsigned S_BIT   = 3
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iREADY,
    output logic [A_BIT-1:0] oADDR,
    output logic             oST_ZERO,
    output logic [S_BIT-1:0] oSTAGE,
    output logic             oADDR_VALID,
    output logic             oCOEF_VALID,
    output logic             oBUSY,
    output logic             oDONE
`ifdef FHT_COEF_ERR_EN
    ,
    output logic             oERR
`endif
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [A_BIT-1:0] BflyMax  = '1;
    localparam logic [S_BIT-1:0] StageMax = S_BIT'(N_STAGE - 1);

    state_e           state;
    logic [S_BIT-1:0] stage_cnt;
    logic [A_BIT-1:0] bfly_cnt;

    logic             accept;
    logic             bfly_last;
    logic             pass_last;
    logic [S_BIT-1:0] stage_nxt;
    logic [A_BIT-1:0] bfly_nxt;

    // Stage s uses the low min(s, A_BIT) butterfly bits, left-justified in the address.
    function automatic logic [A_BIT-1:0] addr_of(input logic [S_BIT-1:0] s,
                                                  input logic [A_BIT-1:0] b);
        int unsigned      m;
        int unsigned      sh;
        logic [A_BIT-1:0] mask;
        m = 32'(s);
        if (m > A_BIT) m = A_BIT;
        sh   = A_BIT - m;
        mask = BflyMax >> sh;
        return (b & mask) << sh;
    endfunction

    // Handshake and counter successor values.
    always_comb begin
        accept    = (state == StRun) & iREADY;
        bfly_last = (bfly_cnt == BflyMax);
        pass_last = bfly_last & (stage_cnt == StageMax);
        bfly_nxt  = bfly_cnt + A_BIT'(1);
        stage_nxt = bfly_last ? stage_cnt + S_BIT'(1) : stage_cnt;
    end

    assign oSTAGE = stage_cnt;

    // Sequencer FSM; all outputs are registered alongside the counters.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state       <= StIdle;
            stage_cnt   <= '0;
            bfly_cnt    <= '0;
            oADDR       <= '0;
            oST_ZERO    <= 1'b0;
            oADDR_VALID <= 1'b0;
            oCOEF_VALID <= 1'b0;
            oBUSY       <= 1'b0;
            oDONE       <= 1'b0;
        end else begin
            // ROM read latency is one cycle, so data validity trails accept.
            oCOEF_VALID <= accept;
            oDONE       <= 1'b0;
            case (state)
                StIdle: begin
                    if (iSTART) begin
                        state       <= StRun;
                        stage_cnt   <= '0;
                        bfly_cnt    <= '0;
                        oADDR       <= '0;
                        oST_ZERO    <= 1'b1;
                        oADDR_VALID <= 1'b1;
                        oBUSY       <= 1'b1;
                    end
                end
                StRun: begin
                    if (accept) begin
                        if (pass_last) begin
                            state       <= StDone;
                            stage_cnt   <= '0;
                            bfly_cnt    <= '0;
                            oADDR       <= '0;
                            oST_ZERO    <= 1'b0;
                            oADDR_VALID <= 1'b0;
                            oDONE       <= 1'b1;
                        end else begin
                            stage_cnt <= stage_nxt;
                            bfly_cnt  <= bfly_nxt;
                            oADDR     <= addr_of(stage_nxt, bfly_nxt);
                            oST_ZERO  <= (stage_nxt == '0);
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    oBUSY <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef FHT_COEF_ERR_EN
    // Sticky flag: a start request arrived while a pass was still in flight.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            oERR <= 1'b0;
        end else if (iSTART && oBUSY) begin
            oERR <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fht_coef_addr_gen.sv
// Scoreboard bench for fht_coef_addr_gen: a small (A_BIT=2, N_STAGE=3)
// instance for directed pass/stall/abort cases and a default instance for
// the full 512-butterfly pass.
module tb_fht_coef_addr_gen;

    typedef struct {
        int addr;
        int stage;
        int stz;
    } exp_t;

    logic       clk;
    logic       s_rst, s_start, s_ready;
    logic [1:0] s_addr;
    logic       s_stz;
    logic [1:0] s_stage;
    logic       s_av, s_cv, s_busy, s_done;
    logic       l_rst, l_start, l_ready;
    logic [5:0] l_addr;
    logic       l_stz;
    logic [2:0] l_stage;
    logic       l_av, l_cv, l_busy, l_done;
`ifdef FHT_COEF_ERR_EN
    logic       s_err, l_err;
`endif

    exp_t sq[$];
    exp_t lq[$];
    exp_t s_e, l_e;
    int   n_checks = 0;
    int   n_pass = 0;
    int   s_coef_cnt = 0, s_done_cnt = 0;
    int   l_coef_cnt = 0, l_done_cnt = 0;
    int   s_tab[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fht_coef_addr_gen #(.A_BIT(2), .N_STAGE(3), .S_BIT(2)) dut_s (
        .iCLK(clk), .iRESET(s_rst), .iSTART(s_start), .iREADY(s_ready),
        .oADDR(s_addr), .oST_ZERO(s_stz), .oSTAGE(s_stage), .oADDR_VALID(s_av),
        .oCOEF_VALID(s_cv), .oBUSY(s_busy), .oDONE(s_done)
`ifdef FHT_COEF_ERR_EN
        , .oERR(s_err)
`endif
    );

    fht_coef_addr_gen dut_l (
        .iCLK(clk), .iRESET(l_rst), .iSTART(l_start), .iREADY(l_ready),
        .oADDR(l_addr), .oST_ZERO(l_stz), .oSTAGE(l_stage), .oADDR_VALID(l_av),
        .oCOEF_VALID(l_cv), .oBUSY(l_busy), .oDONE(l_done)
`ifdef FHT_COEF_ERR_EN
        , .oERR(l_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    function automatic int s_vec();
        return int'({s_addr, s_stz, s_stage, s_av, s_cv, s_busy, s_done});
    endfunction

    function automatic int l_vec();
        return int'({l_addr, l_stz, l_stage, l_av, l_cv, l_busy, l_done});
    endfunction

    // Small-instance monitor: pop and compare on every accepted address.
    always @(negedge clk) begin
        if (!s_rst) begin
            if (s_cv) s_coef_cnt++;
            if (s_done) s_done_cnt++;
            if (s_av && s_ready) begin
                if (sq.size() == 0) begin
                    chk("s_unexpected_accept", 1, 0);
                end else begin
                    s_e = sq.pop_front();
                    chk("s_addr", int'(s_addr), s_e.addr);
                    chk("s_stage", int'(s_stage), s_e.stage);
                    chk("s_st_zero", int'(s_stz), s_e.stz);
                end
            end
        end
    end

    // Default-instance monitor.
    always @(negedge clk) begin
        if (!l_rst) begin
            if (l_cv) l_coef_cnt++;
            if (l_done) l_done_cnt++;
            if (l_av && l_ready) begin
                if (lq.size() == 0) begin
                    chk("l_unexpected_accept", 1, 0);
                end else begin
                    l_e = lq.pop_front();
                    chk("l_addr", int'(l_addr), l_e.addr);
                    chk("l_stage", int'(l_stage), l_e.stage);
                    chk("l_st_zero", int'(l_stz), l_e.stz);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pass on the small instance; optional stall, stray start, or abort.
    task automatic run_pass(input string tag, input int stall_at, input int extra_at,
                            input int abort_at, input int exp_done);
        exp_t e;
        int   c;
        int   d0;
        int   c0;
        bit   aborted;
        for (int i = 0; i < 12; i++) begin
            e.addr  = s_tab[i];
            e.stage = i / 4;
            e.stz   = (i < 4) ? 1 : 0;
            sq.push_back(e);
        end
        d0      = s_done_cnt;
        c0      = s_coef_cnt;
        aborted = 1'b0;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        c = 1;
        chk({tag, "_valid_rise"}, int'(s_av), 1);
        chk({tag, "_busy_rise"}, int'(s_busy), 1);
        while (c < 60) begin
            s_ready = (stall_at > 0 && c >= stall_at && c < stall_at + 3) ? 1'b0 : 1'b1;
            s_start = (c == extra_at);
            if (c == abort_at) begin
                s_rst = 1'b1;
                #1;
                chk({tag, "_abort_clear"}, s_vec(), 0);
                sq.delete();
                step();
                s_rst   = 1'b0;
                s_ready = 1'b1;
                s_start = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (stall_at > 0 && c >= stall_at && c <= stall_at + 3)
                chk({tag, "_stall_addr_hold"}, int'(s_addr), 2);
            if (stall_at > 0 && c > stall_at && c <= stall_at + 3)
                chk({tag, "_stall_coef_low"}, int'(s_cv), 0);
            if (s_done) break;
            step();
            c++;
        end
        s_start = 1'b0;
        s_ready = 1'b1;
        if (aborted) begin
            repeat (3) step();
            chk({tag, "_no_done_after_abort"}, s_done_cnt, d0);
            chk({tag, "_idle_after_abort"}, s_vec(), 0);
`ifdef FHT_COEF_ERR_EN
            chk({tag, "_err_cleared"}, int'(s_err), 0);
`endif
        end else begin
            chk({tag, "_done_cycle"}, c, exp_done);
            chk({tag, "_coef_with_done"}, int'(s_cv), 1);
            step();
            chk({tag, "_busy_fall"}, int'(s_busy), 0);
            chk({tag, "_done_pulse"}, int'(s_done), 0);
            chk({tag, "_coef_pulses"}, s_coef_cnt - c0, 12);
            chk({tag, "_done_count"}, s_done_cnt - d0, 1);
            chk({tag, "_queue_drained"}, sq.size(), 0);
`ifdef FHT_COEF_ERR_EN
            chk({tag, "_err"}, int'(s_err), (extra_at > 0) ? 1 : 0);
`endif
        end
    endtask

    task automatic run_large();
        exp_t e;
        int   c;
        for (int s = 0; s < 8; s++) begin
            for (int b = 0; b < 64; b++) begin
                e.addr  = (s >= 6) ? b : (b % (1 << s)) * (64 >> s);
                e.stage = s;
                e.stz   = (s == 0) ? 1 : 0;
                lq.push_back(e);
            end
        end
        l_start = 1'b1;
        step();
        l_start = 1'b0;
        c = 1;
        while (!l_done && c < 600) begin
            step();
            c++;
        end
        chk("l_done_cycle", c, 513);
        chk("l_coef_with_done", int'(l_cv), 1);
        step();
        chk("l_busy_fall", int'(l_busy), 0);
        repeat (3) step();
        chk("l_coef_pulses", l_coef_cnt, 512);
        chk("l_done_once", l_done_cnt, 1);
        chk("l_queue_drained", lq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_rst   = 1'b1;
        l_rst   = 1'b1;
        s_start = 1'b0;
        l_start = 1'b0;
        s_ready = 1'b1;
        l_ready = 1'b1;
        repeat (2) step();
        s_rst = 1'b0;
        l_rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("s_idle_zero", s_vec(), 0);
            chk("l_idle_zero", l_vec(), 0);
            step();
        end
        run_pass("plain", 0, 0, 0, 13);
        step();
        run_pass("stall", 6, 0, 0, 16);
        step();
        run_pass("stray_start", 0, 9, 0, 13);
        step();
        run_pass("abort", 0, 0, 7, 0);
        run_pass("restart", 0, 0, 0, 13);
        run_large();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
